// File: rtl/action_sequencer_if.sv
// Key levels in, sprite/hitbox controls out, for one fighter.
// The sequencer takes the slave side; the key scanner and renderer take master.
interface action_sequencer_if;
  logic       left;
  logic       right;
  logic       kick;
  logic       fight;
  logic       jump;
  logic       dodge;
  logic [2:0] action;
  logic [3:0] frame_idx;
  logic       move_left;
  logic       move_right;
  logic       facing_left;
  logic       attack_active;
  logic       busy;

  modport master (
    output left, right, kick, fight, jump, dodge,
    input  action, frame_idx, move_left, move_right,
    input  facing_left, attack_active, busy
  );

  modport slave (
    input  left, right, kick, fight, jump, dodge,
    output action, frame_idx, move_left, move_right,
    output facing_left, attack_active, busy
  );
endinterface

// File: rtl/action_sequencer.sv
// Per-player move scheduler: samples keys once per frame, runs a move's
// animation frames and recovery, and buffers one follow-up attack.
module action_sequencer #(
  parameter int KICK_FRAMES  = 6,
  parameter int FIGHT_FRAMES = 4,
  parameter int JUMP_FRAMES  = 8,
  parameter int DODGE_FRAMES = 5,
  parameter int COOLDOWN     = 2,
  parameter int HIT_FRAME    = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  action_sequencer_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_ACTION,
    S_RECOVER
  } state_t;

  localparam logic [2:0] A_STAND = 3'd0;
  localparam logic [2:0] A_WALK  = 3'd1;
  localparam logic [2:0] A_KICK  = 3'd2;
  localparam logic [2:0] A_FIGHT = 3'd3;
  localparam logic [2:0] A_JUMP  = 3'd4;
  localparam logic [2:0] A_DODGE = 3'd5;

  localparam bit NO_CD = (COOLDOWN == 0);
  localparam logic [3:0] CD_INIT =
    NO_CD ? 4'd0 : 4'(COOLDOWN - 1);
  localparam logic [3:0] HIT = 4'(HIT_FRAME);

  state_t     state, nxt_state;
  logic [2:0] act, nxt_act;
  logic [3:0] fidx, nxt_fidx;
  logic [3:0] cd, nxt_cd;
  logic       pv, nxt_pv;
  logic [2:0] pa, nxt_pa;
  logic       face, nxt_face;
  logic       ml, nxt_ml;
  logic       mr, nxt_mr;
  logic       att, nxt_att;
  logic       bsy, nxt_busy;

  logic       req_v;
  logic [2:0] req_a;
  logic       mrg_v;
  logic [2:0] mrg_a;
  logic [3:0] last_idx;
  logic       leave;

  function automatic logic [2:0] rank(
    input logic [2:0] a
  );
    case (a)
      A_DODGE: rank = 3'd4;
      A_JUMP:  rank = 3'd3;
      A_KICK:  rank = 3'd2;
      A_FIGHT: rank = 3'd1;
      default: rank = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] last_frame(
    input logic [2:0] a
  );
    case (a)
      A_KICK:  last_frame = 4'(KICK_FRAMES - 1);
      A_FIGHT: last_frame = 4'(FIGHT_FRAMES - 1);
      A_JUMP:  last_frame = 4'(JUMP_FRAMES - 1);
      A_DODGE: last_frame = 4'(DODGE_FRAMES - 1);
      default: last_frame = 4'd0;
    endcase
  endfunction

  assign last_idx = last_frame(act);

  always_comb begin
    req_v = 1'b1;
    req_a = A_STAND;
    priority case (1'b1)
      io.dodge: req_a = A_DODGE;
      io.jump:  req_a = A_JUMP;
      io.kick:  req_a = A_KICK;
      io.fight: req_a = A_FIGHT;
      default:  req_v = 1'b0;
    endcase
  end

  // Pending as it stands after this tick's key capture.
  always_comb begin
    mrg_v = pv;
    mrg_a = pa;
    if (req_v && (!pv || rank(req_a) > rank(pa))) begin
      mrg_v = 1'b1;
      mrg_a = req_a;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      act   <= A_STAND;
      fidx  <= 4'd0;
      cd    <= 4'd0;
      pv    <= 1'b0;
      pa    <= A_STAND;
      face  <= 1'b0;
      ml    <= 1'b0;
      mr    <= 1'b0;
      att   <= 1'b0;
      bsy   <= 1'b0;
    end else begin
      state <= nxt_state;
      act   <= nxt_act;
      fidx  <= nxt_fidx;
      cd    <= nxt_cd;
      pv    <= nxt_pv;
      pa    <= nxt_pa;
      face  <= nxt_face;
      ml    <= nxt_ml;
      mr    <= nxt_mr;
      att   <= nxt_att;
      bsy   <= nxt_busy;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_act   = act;
    nxt_fidx  = fidx;
    nxt_cd    = cd;
    nxt_pv    = pv;
    nxt_pa    = pa;
    nxt_face  = face;
    leave     = 1'b0;
    if (frame_tick) begin
      unique case (state)
        S_IDLE, S_WALK: begin
          nxt_fidx = 4'd0;
          nxt_pv   = 1'b0;
          if (req_v) begin
            nxt_state = S_ACTION;
            nxt_act   = req_a;
          end else if (io.left ^ io.right) begin
            nxt_state = S_WALK;
            nxt_act   = A_WALK;
            nxt_face  = io.left;
          end else begin
            nxt_state = S_IDLE;
            nxt_act   = A_STAND;
          end
        end
        S_ACTION: begin
          nxt_pv = mrg_v;
          nxt_pa = mrg_a;
          if (fidx < last_idx) begin
            nxt_fidx = fidx + 4'd1;
          end else if (!NO_CD) begin
            nxt_state = S_RECOVER;
            nxt_act   = A_STAND;
            nxt_fidx  = 4'd0;
            nxt_cd    = CD_INIT;
          end else begin
            leave = 1'b1;
          end
        end
        S_RECOVER: begin
          nxt_pv   = mrg_v;
          nxt_pa   = mrg_a;
          nxt_act  = A_STAND;
          nxt_fidx = 4'd0;
          if (cd == 4'd0) leave = 1'b1;
          else nxt_cd = cd - 4'd1;
        end
      endcase
      // Follow-up move starts directly, no idle frame in between.
      if (leave) begin
        nxt_fidx = 4'd0;
        nxt_pv   = 1'b0;
        if (mrg_v) begin
          nxt_state = S_ACTION;
          nxt_act   = mrg_a;
        end else begin
          nxt_state = S_IDLE;
          nxt_act   = A_STAND;
        end
      end
    end
  end

  always_comb begin
    nxt_busy = (nxt_state == S_ACTION) ||
               (nxt_state == S_RECOVER);
    nxt_ml   = (nxt_state == S_WALK) && nxt_face;
    nxt_mr   = (nxt_state == S_WALK) && !nxt_face;
    nxt_att  = (nxt_state == S_ACTION) &&
               ((nxt_act == A_KICK) ||
                (nxt_act == A_FIGHT)) &&
               (nxt_fidx == HIT);
  end

  assign io.action        = act;
  assign io.frame_idx     = fidx;
  assign io.move_left     = ml;
  assign io.move_right    = mr;
  assign io.facing_left   = face;
  assign io.attack_active = att;
  assign io.busy          = bsy;

endmodule
